// File: rtl/msm_naive_core_if.sv
// Curve point type and the MSM core's data bundle: base points and scalars in,
// result point and completion flag out.
package elliptic_curve_structs;
    typedef struct packed {
        logic [255:0] x;
        logic [255:0] y;
    } curve_point_t;
endpackage

interface msm_naive_core_if #(parameter int length = 2);
    import elliptic_curve_structs::*;
    curve_point_t [length-1:0]        G;
    logic         [length-1:0][255:0] x;
    curve_point_t                     R;
    logic                             Done;

    modport master (output G, x, input R, Done);
    modport slave  (input G, x, output R, Done);
endinterface

// File: rtl/msm_naive_core.sv
// Naive affine-coordinate MSM: per-term MSB-first double-and-add, with terms summed
// into one accumulator. The field mul and inv engines are shared by every point op.
module msm_naive_core
    import elliptic_curve_structs::*;
#(
    parameter int           length = 2,
    parameter logic [255:0] P      = 256'd37,
    parameter logic [255:0] A      = 256'd0
) (
    input  logic             clk,
    input  logic             Reset,
    msm_naive_core_if.slave  bus
);
    localparam int IW = (length > 1) ? $clog2(length) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SCAN, S_PSTART, S_PDBL, S_INV,
        S_PLAM, S_PX3, S_PY3, S_PEND, S_MUL, S_DONE
    } state_t;
    typedef enum logic [1:0] {T_DBL, T_ADD, T_ACC} tag_t;

    function automatic logic [255:0] f_add(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return 256'(s);
    endfunction

    function automatic logic [255:0] f_sub(input logic [255:0] a, input logic [255:0] b);
        return (a >= b) ? (a - b) : (a + (P - b));
    endfunction

    function automatic logic [255:0] f_half(input logic [255:0] a);
        logic [256:0] s;
        s = a[0] ? ({1'b0, a} + {1'b0, P}) : {1'b0, a};
        return 256'(s >> 1);
    endfunction

    // One interleaved shift-add step: acc = 2*acc + bit*a, kept below P.
    function automatic logic [255:0] f_mstep(input logic [255:0] acc, input logic [255:0] a,
                                             input logic bitv);
        logic [256:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, P}) t = t - {1'b0, P};
        if (bitv) t = t + {1'b0, a};
        if (t >= {1'b0, P}) t = t - {1'b0, P};
        return 256'(t);
    endfunction

    state_t state_q, state_d, ret_q, ret_d;
    tag_t   tag_q, tag_d;
    curve_point_t [length-1:0]        g_q, g_d;
    logic         [length-1:0][255:0] xs_q, xs_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    bit_q, bit_d, mcnt_q, mcnt_d;
    logic          add_ph_q, add_ph_d, acc_inf_q, acc_inf_d, q_inf_q, q_inf_d;
    logic          o1_inf_q, o1_inf_d, o2_inf_q, o2_inf_d, dbl_q, dbl_d;
    logic          res_inf_q, res_inf_d, done_q, done_d;
    curve_point_t  acc_q, acc_d, qp_q, qp_d, o1_q, o1_d, o2_q, o2_d;
    curve_point_t  res_q, res_d, r_q, r_d;
    logic [255:0]  num_q, num_d, lam_q, lam_d, ma_q, ma_d, mb_q, mb_d, mr_q, mr_d;
    logic [255:0]  u_q, u_d, v_q, v_d, ix1_q, ix1_d, ix2_q, ix2_d;
    logic          adv, cur_bit;
    logic [255:0]  den, inv, x3;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;  ret_q <= S_IDLE;  tag_q <= T_DBL;
            g_q <= '0;  xs_q <= '0;  idx_q <= '0;  bit_q <= '0;  mcnt_q <= '0;
            add_ph_q <= 1'b0;  acc_inf_q <= 1'b0;  q_inf_q <= 1'b0;
            o1_inf_q <= 1'b0;  o2_inf_q <= 1'b0;  dbl_q <= 1'b0;
            res_inf_q <= 1'b0;  done_q <= 1'b0;
            acc_q <= '0;  qp_q <= '0;  o1_q <= '0;  o2_q <= '0;  res_q <= '0;  r_q <= '0;
            num_q <= '0;  lam_q <= '0;  ma_q <= '0;  mb_q <= '0;  mr_q <= '0;
            u_q <= '0;  v_q <= '0;  ix1_q <= '0;  ix2_q <= '0;
        end else begin
            state_q <= state_d;  ret_q <= ret_d;  tag_q <= tag_d;
            g_q <= g_d;  xs_q <= xs_d;  idx_q <= idx_d;  bit_q <= bit_d;  mcnt_q <= mcnt_d;
            add_ph_q <= add_ph_d;  acc_inf_q <= acc_inf_d;  q_inf_q <= q_inf_d;
            o1_inf_q <= o1_inf_d;  o2_inf_q <= o2_inf_d;  dbl_q <= dbl_d;
            res_inf_q <= res_inf_d;  done_q <= done_d;
            acc_q <= acc_d;  qp_q <= qp_d;  o1_q <= o1_d;  o2_q <= o2_d;  res_q <= res_d;  r_q <= r_d;
            num_q <= num_d;  lam_q <= lam_d;  ma_q <= ma_d;  mb_q <= mb_d;  mr_q <= mr_d;
            u_q <= u_d;  v_q <= v_d;  ix1_q <= ix1_d;  ix2_q <= ix2_d;
        end
    end

    always_comb begin
        state_d = state_q;  ret_d = ret_q;  tag_d = tag_q;
        g_d = g_q;  xs_d = xs_q;  idx_d = idx_q;  bit_d = bit_q;  mcnt_d = mcnt_q;
        add_ph_d = add_ph_q;  acc_inf_d = acc_inf_q;  q_inf_d = q_inf_q;
        o1_inf_d = o1_inf_q;  o2_inf_d = o2_inf_q;  dbl_d = dbl_q;
        res_inf_d = res_inf_q;  done_d = done_q;
        acc_d = acc_q;  qp_d = qp_q;  o1_d = o1_q;  o2_d = o2_q;  res_d = res_q;  r_d = r_q;
        num_d = num_q;  lam_d = lam_q;  ma_d = ma_q;  mb_d = mb_q;  mr_d = mr_q;
        u_d = u_q;  v_d = v_q;  ix1_d = ix1_q;  ix2_d = ix2_q;
        adv = 1'b0;  den = '0;  inv = '0;  x3 = '0;
        cur_bit = xs_q[idx_q][bit_q];

        case (state_q)
            S_IDLE: begin
                g_d = bus.G;  xs_d = bus.x;  idx_d = '0;  acc_inf_d = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                q_inf_d = 1'b1;  add_ph_d = 1'b0;  bit_d = 8'd255;  state_d = S_SCAN;
            end
            S_SCAN: begin
                if (!add_ph_q && !q_inf_q) begin
                    o1_d = qp_q;  o1_inf_d = 1'b0;  o2_d = qp_q;  o2_inf_d = 1'b0;
                    dbl_d = 1'b1;  tag_d = T_DBL;  state_d = S_PSTART;
                end else if (cur_bit && q_inf_q) begin
                    // inf + G is G: no point op needed
                    qp_d = g_q[idx_q];  q_inf_d = 1'b0;  adv = 1'b1;
                end else if (cur_bit) begin
                    o1_d = qp_q;  o1_inf_d = 1'b0;  o2_d = g_q[idx_q];  o2_inf_d = 1'b0;
                    dbl_d = 1'b0;  tag_d = T_ADD;  state_d = S_PSTART;
                end else begin
                    adv = 1'b1;
                end
            end
            S_PSTART: begin
                if (dbl_q) begin
                    if (o1_inf_q || o1_q.y == '0) begin
                        res_inf_d = 1'b1;  state_d = S_PEND;
                    end else begin
                        ma_d = o1_q.x;  mb_d = o1_q.x;  mr_d = '0;  mcnt_d = 8'd255;
                        ret_d = S_PDBL;  state_d = S_MUL;
                    end
                end else if (o1_inf_q) begin
                    res_d = o2_q;  res_inf_d = o2_inf_q;  state_d = S_PEND;
                end else if (o2_inf_q) begin
                    res_d = o1_q;  res_inf_d = 1'b0;  state_d = S_PEND;
                end else if (o1_q.x == o2_q.x) begin
                    // equal points re-enter this state as a doubling; P + (-P) is infinity
                    if (o1_q.y == o2_q.y) dbl_d = 1'b1;
                    else begin res_inf_d = 1'b1;  state_d = S_PEND; end
                end else begin
                    num_d = f_sub(o2_q.y, o1_q.y);  den = f_sub(o2_q.x, o1_q.x);
                    u_d = den;  v_d = P;  ix1_d = 256'd1;  ix2_d = '0;  state_d = S_INV;
                end
            end
            S_PDBL: begin
                num_d = f_add(f_add(f_add(mr_q, mr_q), mr_q), A);
                den   = f_add(o1_q.y, o1_q.y);
                u_d = den;  v_d = P;  ix1_d = 256'd1;  ix2_d = '0;  state_d = S_INV;
            end
            S_INV: begin
                // invariant: ix1*den == u and ix2*den == v (mod P)
                if (u_q == 256'd1 || v_q == 256'd1) begin
                    inv  = (u_q == 256'd1) ? ix1_q : ix2_q;
                    ma_d = num_q;  mb_d = inv;  mr_d = '0;  mcnt_d = 8'd255;
                    ret_d = S_PLAM;  state_d = S_MUL;
                end else if (!u_q[0]) begin
                    u_d = u_q >> 1;  ix1_d = f_half(ix1_q);
                end else if (!v_q[0]) begin
                    v_d = v_q >> 1;  ix2_d = f_half(ix2_q);
                end else if (u_q >= v_q) begin
                    u_d = u_q - v_q;  ix1_d = f_sub(ix1_q, ix2_q);
                end else begin
                    v_d = v_q - u_q;  ix2_d = f_sub(ix2_q, ix1_q);
                end
            end
            S_PLAM: begin
                lam_d = mr_q;  ma_d = mr_q;  mb_d = mr_q;  mr_d = '0;  mcnt_d = 8'd255;
                ret_d = S_PX3;  state_d = S_MUL;
            end
            S_PX3: begin
                x3 = f_sub(f_sub(mr_q, o1_q.x), dbl_q ? o1_q.x : o2_q.x);
                res_d.x = x3;
                ma_d = lam_q;  mb_d = f_sub(o1_q.x, x3);  mr_d = '0;  mcnt_d = 8'd255;
                ret_d = S_PY3;  state_d = S_MUL;
            end
            S_PY3: begin
                res_d.y = f_sub(mr_q, o1_q.y);  res_inf_d = 1'b0;  state_d = S_PEND;
            end
            S_PEND: begin
                case (tag_q)
                    T_DBL: begin
                        qp_d = res_q;  q_inf_d = res_inf_q;  add_ph_d = 1'b1;  state_d = S_SCAN;
                    end
                    T_ADD: begin
                        qp_d = res_q;  q_inf_d = res_inf_q;  adv = 1'b1;
                    end
                    default: begin
                        acc_d = res_q;  acc_inf_d = res_inf_q;
                        if (idx_q == IW'(length - 1)) begin
                            done_d = 1'b1;  r_d = res_inf_q ? '0 : res_q;  state_d = S_DONE;
                        end else begin
                            idx_d = idx_q + IW'(1);  state_d = S_LOAD;
                        end
                    end
                endcase
            end
            S_MUL: begin
                mr_d = f_mstep(mr_q, ma_q, mb_q[mcnt_q]);
                if (mcnt_q == 8'd0) state_d = ret_q;
                else mcnt_d = mcnt_q - 8'd1;
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        // Bit finished: step to the next one, or fold the term into the accumulator.
        if (adv) begin
            add_ph_d = 1'b0;
            if (bit_q == 8'd0) begin
                o1_d = acc_q;  o1_inf_d = acc_inf_q;  o2_d = qp_d;  o2_inf_d = q_inf_d;
                dbl_d = 1'b0;  tag_d = T_ACC;  state_d = S_PSTART;
            end else begin
                bit_d = bit_q - 8'd1;  state_d = S_SCAN;
            end
        end
    end

    assign bus.R    = r_q;
    assign bus.Done = done_q;
endmodule

// File: tb/tb_msm_naive_core.sv
// Scoreboard bench for msm_naive_core on y^2 = x^3 + 7 mod 37 with two terms.
module tb_msm_naive_core;
    import elliptic_curve_structs::*;

    localparam int BUDGET = 200000;

    logic clk = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    curve_point_t exp_q[$];

    msm_naive_core_if #(.length(2)) bus();
    msm_naive_core #(.length(2), .P(256'd37), .A(256'd0)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic curve_point_t pt(input int px, input int py);
        curve_point_t p;
        p.x = 256'(px);
        p.y = 256'(py);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Hold reset with new inputs, verify the cleared outputs, queue the expected result, release.
    task automatic start(input string tag, input curve_point_t g0, input curve_point_t g1,
                         input int x0, input int x1, input curve_point_t r);
        Reset = 1'b0;
        bus.G[0] = g0;  bus.G[1] = g1;
        bus.x[0] = 256'(x0);  bus.x[1] = 256'(x1);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rst_done"}, 512'(bus.Done), 512'(0));
        chk({tag, "_rst_R"}, bus.R, 512'(0));
        exp_q.push_back(r);
        @(negedge clk);
        Reset = 1'b1;
    endtask

    task automatic finish_case(input string tag);
        int n;
        bit early;
        curve_point_t e;
        n = 0;
        early = 1'b0;
        while (bus.Done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (bus.Done !== 1'b1 && bus.R !== '0) early = 1'b1;
        end
        chk({tag, "_timeout"}, 512'(n >= BUDGET), 512'(0));
        chk({tag, "_R_before_done"}, 512'(early), 512'(0));
        e = exp_q.pop_front();
        chk({tag, "_R"}, bus.R, e);
    endtask

    initial begin
        bus.G = '0;
        bus.x = '0;

        start("c1", pt(6, 1), pt(17, 6), 18, 80, pt(16, 25));
        finish_case("c1");
        // Inputs changed after completion must not disturb the result.
        bus.x[0] = 256'd5;
        bus.G[1] = pt(1, 1);
        repeat (20) @(negedge clk);
        chk("c6_hold_R", bus.R, pt(16, 25));
        chk("c6_hold_done", 512'(bus.Done), 512'(1));
        Reset = 1'b0;
        #1;
        chk("c6_async_done", 512'(bus.Done), 512'(0));
        chk("c6_async_R", bus.R, 512'(0));

        start("c2a", pt(6, 1), pt(17, 6), 18, 0, pt(24, 17));
        finish_case("c2a");
        start("c2b", pt(6, 1), pt(17, 6), 0, 80, pt(13, 24));
        finish_case("c2b");
        start("c3a", pt(6, 1), pt(17, 6), 1, 0, pt(6, 1));
        finish_case("c3a");
        start("c3b", pt(6, 1), pt(17, 6), 0, 0, pt(0, 0));
        finish_case("c3b");
        chk("c3b_done", 512'(bus.Done), 512'(1));
        start("c4a", pt(6, 1), pt(6, 36), 1, 1, pt(0, 0));
        finish_case("c4a");
        // 2*(6,1): lambda = 108/2 = 17, x3 = 289-12 = 18, y3 = 17*(6-18)-1 = 17 (mod 37)
        start("c4b", pt(6, 1), pt(6, 1), 1, 1, pt(18, 17));
        finish_case("c4b");
        start("c4c", pt(6, 1), pt(17, 6), 2, 0, pt(18, 17));
        finish_case("c4c");

        // Abort mid-scan, then restart with different scalars.
        start("c5a", pt(6, 1), pt(17, 6), 18, 80, pt(16, 25));
        repeat (3000) @(negedge clk);
        chk("c5_mid_done", 512'(bus.Done), 512'(0));
        Reset = 1'b0;
        #1;
        chk("c5_abort_done", 512'(bus.Done), 512'(0));
        chk("c5_abort_R", bus.R, 512'(0));
        void'(exp_q.pop_front());
        start("c5b", pt(6, 1), pt(17, 6), 18, 0, pt(24, 17));
        finish_case("c5b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
